pipe_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the SimpleCPU execute stage. It accepts one shift operation per cycle over a valid/ready handshake and resolves one shift-amount bit per pipeline stage. It returns the full-width result together with a caller tag after a fixed latency. It adds rotates, a carried tag, backpressure and a synchronous flush for branch-mispredict squash.

---
 rtl/shifter_pkg.sv | 18 +
 rtl/shift_stage.sv | 71 +++++++
 rtl/pipe_shifter.sv | 88 ++++++++
 tb/tb_pipe_shifter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared op encodings and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SRL = 3'b000,
        OP_SRA = 3'b001,
        OP_SLL = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } shift_op_t;

    localparam logic [2:0] OP_LAST = 3'b100;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditionally shifts the incoming word by 2^K and
// registers it with its sideband, holding while the stage is stalled.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5,
    parameter int SHW   = 5,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  shift_op_t        prev_op,
    input  logic [SHW-1:0]   prev_shamt,
    input  logic [TAGW-1:0]  prev_tag,
    input  logic             prev_illegal,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output shift_op_t        op,
    output logic [SHW-1:0]   shamt,
    output logic [TAGW-1:0]  tag,
    output logic             illegal
);

    localparam int AMT = 1 << K;

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = prev_data;
        if (prev_shamt[K]) begin
            case (prev_op)
                OP_SRL:  shifted = prev_data >> AMT;
                OP_SRA:  shifted = $unsigned($signed(prev_data) >>> AMT);
                OP_SLL:  shifted = prev_data << AMT;
                OP_ROR:  shifted = (prev_data >> AMT) | (prev_data << (WIDTH - AMT));
                OP_ROL:  shifted = (prev_data << AMT) | (prev_data >> (WIDTH - AMT));
                default: shifted = prev_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            data    <= '0;
            op      <= OP_SRL;
            shamt   <= '0;
            tag     <= '0;
            illegal <= 1'b0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (!stall)
                valid <= prev_valid;
            // Payload only moves with a real item so a drained stage keeps its last value.
            if (!stall && prev_valid) begin
                data    <= shifted;
                op      <= prev_op;
                shamt   <= prev_shamt;
                tag     <= prev_tag;
                illegal <= prev_illegal;
            end
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: one shift-amount bit resolved per stage, with
// valid/ready flow control, collapsing bubbles and a synchronous flush.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int TAGW  = 5,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       operation,
    input  logic [TAGW-1:0]  tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [TAGW-1:0]  res_tag,
    output logic             illegal
);

    logic                        legal;
    logic                        accept;
    logic [SHW-1:0]              vld_pipe;
    logic [SHW-1:0]              stall;
    logic [SHW:0][WIDTH-1:0]     data_pipe;
    shift_op_t [SHW:0]           op_pipe;
    logic [SHW:0][SHW-1:0]       shamt_pipe;
    logic [SHW:0][TAGW-1:0]      tag_pipe;
    logic [SHW:0]                ill_pipe;
    logic                        unused_tail;

    assign legal         = is_legal_op(operation);
    assign in_ready      = !flush && !stall[0];
    assign accept        = in_valid && in_ready;
    assign data_pipe[0]  = legal ? op1 : '0;
    assign op_pipe[0]    = legal ? shift_op_t'(operation) : OP_SRL;
    assign shamt_pipe[0] = shamt;
    assign tag_pipe[0]   = tag;
    assign ill_pipe[0]   = !legal;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        // A stage stalls only when it and every stage after it are full and the sink is blocked.
        assign stall[k] = !out_ready && (&vld_pipe[SHW-1:k]);

        logic prev_valid;
        if (k == 0) begin : g_head
            assign prev_valid = accept;
        end else begin : g_body
            assign prev_valid = vld_pipe[k-1];
        end

        shift_stage #(
            .WIDTH(WIDTH),
            .TAGW (TAGW),
            .SHW  (SHW),
            .K    (k)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .stall       (stall[k]),
            .prev_valid  (prev_valid),
            .prev_data   (data_pipe[k]),
            .prev_op     (op_pipe[k]),
            .prev_shamt  (shamt_pipe[k]),
            .prev_tag    (tag_pipe[k]),
            .prev_illegal(ill_pipe[k]),
            .valid       (vld_pipe[k]),
            .data        (data_pipe[k+1]),
            .op          (op_pipe[k+1]),
            .shamt       (shamt_pipe[k+1]),
            .tag         (tag_pipe[k+1]),
            .illegal     (ill_pipe[k+1])
        );
    end

    assign out_valid   = vld_pipe[SHW-1];
    assign res         = data_pipe[SHW];
    assign res_tag     = tag_pipe[SHW];
    assign illegal     = ill_pipe[SHW];
    assign unused_tail = ^{shamt_pipe[SHW], op_pipe[SHW]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter: directed scenarios plus random traffic
// against a queue-based reference model of the shifter.
module tb_pipe_shifter;

    localparam int WIDTH = 32;
    localparam int TAGW  = 5;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [SHW-1:0]   shamt;
    logic [2:0]       operation;
    logic [TAGW-1:0]  tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [TAGW-1:0]  res_tag;
    logic             illegal;

    pipe_shifter #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op1      (op1),
        .shamt    (shamt),
        .operation(operation),
        .tag      (tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res),
        .res_tag  (res_tag),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic [TAGW-1:0]  t;
        logic             i;
    } exp_t;

    exp_t             q[$];
    int               n_vec = 0;
    int               n_bad = 0;
    int               npop = 0;
    logic             seen;
    logic [WIDTH-1:0] last_res;
    logic             last_ill;
    logic             stalled_prev = 1'b0;
    logic [WIDTH-1:0] prev_res;
    logic [TAGW-1:0]  prev_tag;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Rotates use a doubled word; shifts use plain SV operators on the whole amount.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [SHW-1:0] s,
                                   input logic [2:0] o, input logic [TAGW-1:0] t);
        exp_t        e;
        logic [63:0] dbl;
        dbl = {a, a};
        e.t = t;
        e.i = 1'b0;
        case (o)
            3'd0: e.r = a >> s;
            3'd1: e.r = $unsigned($signed(a) >>> s);
            3'd2: e.r = a << s;
            3'd3: begin dbl = dbl >> s; e.r = dbl[31:0];  end
            3'd4: begin dbl = dbl << s; e.r = dbl[63:32]; end
            default: begin e.r = '0; e.i = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [SHW-1:0] s,
                         input logic [2:0] o, input logic [TAGW-1:0] t, input logic ordy,
                         input logic fl);
        in_valid = v; op1 = a; shamt = s; operation = o; tag = t; out_ready = ordy; flush = fl;
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic cyc();
        exp_t e;
        #1;
        chk("in_ready", in_ready, !flush && (q.size() < SHW || out_ready));
        if (stalled_prev) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_hold", {res_tag, res}, {prev_tag, prev_res});
        end
        seen = out_valid;
        if (out_valid) begin last_res = res; last_ill = illegal; end
        if (out_valid && out_ready) begin
            chk("out_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("res", res, e.r);
                chk("res_tag", res_tag, e.t);
                chk("illegal", illegal, e.i);
                npop++;
            end
        end
        stalled_prev = out_valid && !out_ready && !flush && rst_n;
        prev_res = res;
        prev_tag = res_tag;
        if (in_valid && in_ready) q.push_back(model(op1, shamt, operation, tag));
        if (flush || !rst_n) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
            cyc();
        end
    endtask

    task automatic lat_test(input logic [WIDTH-1:0] a, input logic [SHW-1:0] s,
                            input logic [2:0] o, input logic [TAGW-1:0] t,
                            input logic [WIDTH-1:0] want, input logic want_ill);
        int n;
        drive(1'b1, a, s, o, t, 1'b1, 1'b0);
        cyc();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            drive(1'b0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
            n++;
            cyc();
        end
        chk("latency", n, SHW);
        chk("res_direct", last_res, want);
        chk("ill_direct", last_ill, want_ill);
    endtask

    initial begin
        int sent;
        int pop0;
        logic [WIDTH-1:0] hold_res;

        rst_n = 1'b0;
        drive(1'b0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_res", res, '0);
        chk("rst_res_tag", res_tag, '0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        lat_test(32'h8000_0000, 5'd4,  3'd0, 5'd1, 32'h0800_0000, 1'b0);
        lat_test(32'h8000_0000, 5'd4,  3'd1, 5'd2, 32'hF800_0000, 1'b0);
        lat_test(32'h8000_0000, 5'd4,  3'd2, 5'd3, 32'h0000_0000, 1'b0);
        lat_test(32'h8000_0001, 5'd1,  3'd4, 5'd4, 32'h0000_0003, 1'b0);
        lat_test(32'h0000_0001, 5'd31, 3'd3, 5'd5, 32'h0000_0002, 1'b0);
        for (int o = 0; o < 5; o++)
            lat_test(32'h1234_5678, 5'd0, 3'(o), 5'(o), 32'h1234_5678, 1'b0);

        // Illegal op followed by a legal one.
        lat_test(32'hFFFF_FFFF, 5'd7, 3'b110, 5'd9, 32'h0, 1'b1);
        lat_test(32'hFFFF_FFFF, 5'd8, 3'd0, 5'd10, 32'h00FF_FFFF, 1'b0);

        // Back-to-back with the sink blocked in cycles 5..12.
        sent = 0;
        pop0 = npop;
        for (int c = 0; c < 40; c++) begin
            drive(sent < 8, $urandom, 5'($urandom), 3'($urandom_range(0, 4)), 5'(sent),
                  !(c >= 5 && c <= 12), 1'b0);
            #1;
            if (c == 5) chk("bp_in_ready_low", in_ready, 1'b0);
            if (c == 6) hold_res = res;
            if (c == 12) begin
                chk("bp_hold_valid", out_valid, 1'b1);
                chk("bp_hold_res", res, hold_res);
            end
            if (in_valid && in_ready) sent++;
            cyc();
        end
        chk("bp_count", npop - pop0, 8);

        // Flush with three in flight.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, $urandom, 5'($urandom), 3'd2, 5'(20 + c), 1'b1, 1'b0);
            cyc();
        end
        drive(1'b1, 32'hDEAD_BEEF, 5'd3, 3'd0, 5'd30, 1'b1, 1'b1);
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        cyc();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
            #1;
            chk("flush_no_out", out_valid, 1'b0);
            cyc();
        end
        lat_test(32'h0000_00F0, 5'd4, 3'd0, 5'd11, 32'h0000_000F, 1'b0);

        // Reset with four pending.
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, $urandom, 5'($urandom), 3'd3, 5'(c), 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_res", res, '0);
        chk("mid_rst_tag", res_tag, '0);
        chk("mid_rst_illegal", illegal, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        idle(10);

        // Random traffic with backpressure and occasional flush.
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) < 7, $urandom, 5'($urandom), 3'($urandom_range(0, 7)),
                  5'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
            cyc();
        end
        idle(12);
        chk("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
